// File: rtl/decoder_scan_pkg.sv
// Shared constants and FSM encoding for the 3-to-8 decoder scan sequencer.
package decoder_scan_pkg;

   localparam int SEL_W  = 3;
   localparam int NLINES = 2 ** SEL_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/scan_next_sel.sv
// Masked circular search: first set mask bit strictly after cur, wrapping around
// (cur itself is the last candidate, so a one-line mask returns the same line).
module scan_next_sel
   import decoder_scan_pkg::*;
(
   input  logic [NLINES-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   output logic [SEL_W-1:0]  nxt,
   output logic              wrap,
   output logic              any
);

   logic [SEL_W-1:0] idx;
   logic             found;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      nxt   = '0;
      wrap  = 1'b0;
      found = 1'b0;
      idx   = '0;
      any   = |mask;
      for (int k = 1; k <= NLINES; k++) begin
         idx = cur + SEL_W'(k);
         if (!found && mask[idx]) begin
            found = 1'b1;
            nxt   = idx;
            wrap  = (idx <= cur);
         end
      end
   end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Drives decoder select/enable so each masked line is strobed for a dwell time,
// with optional blank gaps; single-shot or continuous sweeps. All outputs registered.
module decoder_scan_ctrl
   import decoder_scan_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              mode_cont,
   input  logic [NLINES-1:0] mask,
   input  logic [CNT_W-1:0]  dwell,
   input  logic [CNT_W-1:0]  gap,
   output logic [SEL_W-1:0]  sel,
   output logic              en,
   output logic              busy,
   output logic              line_done,
   output logic              sweep_done
);

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic               cfg_cont, cfg_cont_d;
   logic [NLINES-1:0]  cfg_mask, cfg_mask_d;
   logic [CNT_W-1:0]   cfg_dwell, cfg_dwell_d;
   logic [CNT_W-1:0]   cfg_gap, cfg_gap_d;
   logic [SEL_W-1:0]   sel_d, nxt_q;
   logic               en_d, busy_d, line_done_d, sweep_done_d;

   logic [SEL_W-1:0]   first_sel, look_sel;
   logic               first_any, first_wrap, look_wrap, look_any;
   logic               unused_flags;

   // Lowest set bit of the live mask: a circular search starting after the top line.
   scan_next_sel u_first (
      .mask (mask),
      .cur  (SEL_W'(NLINES - 1)),
      .nxt  (first_sel),
      .wrap (first_wrap),
      .any  (first_any)
   );

   // Look one cycle ahead on the line being driven next, so the successor and
   // the "highest masked line" flag are ready as registers when the line ends.
   scan_next_sel u_look (
      .mask (cfg_mask_d),
      .cur  (sel_d),
      .nxt  (look_sel),
      .wrap (look_wrap),
      .any  (look_any)
   );

   assign unused_flags = first_wrap ^ look_any;

   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      sel_d       = sel;
      en_d        = en;
      busy_d      = busy;
      cfg_cont_d  = cfg_cont;
      cfg_mask_d  = cfg_mask;
      cfg_dwell_d = cfg_dwell;
      cfg_gap_d   = cfg_gap;

      if (stop) begin
         state_d = IDLE;
         en_d    = 1'b0;
         busy_d  = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               en_d   = 1'b0;
               busy_d = 1'b0;
               if (start && first_any) begin
                  cfg_cont_d  = mode_cont;
                  cfg_mask_d  = mask;
                  cfg_dwell_d = dwell;
                  cfg_gap_d   = gap;
                  state_d     = ON;
                  sel_d       = first_sel;
                  en_d        = 1'b1;
                  busy_d      = 1'b1;
                  cnt_d       = (dwell == '0) ? '0 : dwell - 1'b1;
               end
            end
            ON: begin
               if (cnt != '0) begin
                  cnt_d = cnt - 1'b1;
               end else if (!cfg_cont && sweep_done) begin
                  state_d = IDLE;
                  en_d    = 1'b0;
                  busy_d  = 1'b0;
               end else if (cfg_gap == '0) begin
                  sel_d = nxt_q;
                  cnt_d = (cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1;
               end else begin
                  state_d = GAP;
                  en_d    = 1'b0;
                  cnt_d   = cfg_gap - 1'b1;
               end
            end
            GAP: begin
               if (cnt != '0) begin
                  cnt_d = cnt - 1'b1;
               end else begin
                  state_d = ON;
                  sel_d   = nxt_q;
                  en_d    = 1'b1;
                  cnt_d   = (cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               en_d    = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end

      // The final enable-high cycle of a line is the ON cycle whose count is zero.
      line_done_d  = (state_d == ON) && (cnt_d == '0);
      sweep_done_d = line_done_d && look_wrap;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the latched configuration is reset too, so nothing in the block powers up unknown.
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sel        <= '0;
         en         <= 1'b0;
         busy       <= 1'b0;
         line_done  <= 1'b0;
         sweep_done <= 1'b0;
         nxt_q      <= '0;
         cfg_cont   <= 1'b0;
         cfg_mask   <= '0;
         cfg_dwell  <= '0;
         cfg_gap    <= '0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         sel        <= sel_d;
         en         <= en_d;
         busy       <= busy_d;
         line_done  <= line_done_d;
         sweep_done <= sweep_done_d;
         nxt_q      <= look_sel;
         cfg_cont   <= cfg_cont_d;
         cfg_mask   <= cfg_mask_d;
         cfg_dwell  <= cfg_dwell_d;
         cfg_gap    <= cfg_gap_d;
      end
   end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench: table of hand-derived per-run totals, a trace model built
// from the sweep rules, randomized configs, and hand sequences for corner cases.
module tb_decoder_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       mode_cont = 1'b0;
   logic [7:0] mask = '0;
   logic [7:0] dwell = '0;
   logic [7:0] gap = '0;
   logic [2:0] sel;
   logic       en, busy, line_done, sweep_done;

   int n_checks = 0;
   int n_err    = 0;

   decoder_scan_ctrl #(.CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .mode_cont  (mode_cont),
      .mask       (mask),
      .dwell      (dwell),
      .gap        (gap),
      .sel        (sel),
      .en         (en),
      .busy       (busy),
      .line_done  (line_done),
      .sweep_done (sweep_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] sel;
      logic       en;
      logic       busy;
      logic       ld;
      logic       sd;
   } obs_t;

   typedef struct {
      logic [7:0] mask;
      logic [7:0] dwell;
      logic [7:0] gap;
      logic       cont;
      int         run;
      int         n_en;
      int         n_ld;
      int         n_sd;
      int         n_busy;
   } vec_t;

   obs_t exp_q[$];
   vec_t tbl[7];

   function automatic obs_t observe();
      return '{sel: sel, en: en, busy: busy, ld: line_done, sd: sweep_done};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Expected output trace written directly from the sweep description: each
   // masked line ascending for max(dwell,1) cycles, then gap blank cycles.
   task automatic build_trace(input logic [7:0] m, input logic [7:0] d, input logic [7:0] g,
                              input logic c, input int len);
      int hi;
      int dw;
      exp_q.delete();
      hi = 0;
      for (int i = 0; i < 8; i++) if (m[i]) hi = i;
      dw = (d == 0) ? 1 : int'(d);
      do begin
         for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
               for (int k = 0; k < dw; k++)
                  exp_q.push_back('{sel: 3'(i), en: 1'b1, busy: 1'b1,
                                    ld: (k == dw - 1), sd: (k == dw - 1) && (i == hi)});
               if (c || i != hi)
                  for (int k = 0; k < int'(g); k++)
                     exp_q.push_back('{sel: 3'(i), en: 1'b0, busy: 1'b1, ld: 1'b0, sd: 1'b0});
            end
         end
      end while (c && exp_q.size() < len);
      while (exp_q.size() < len + 1)
         exp_q.push_back('{sel: 3'(hi), en: 1'b0, busy: 1'b0, ld: 1'b0, sd: 1'b0});
   endtask

   // Start one configuration, compare every cycle against the trace, then stop.
   task automatic run_case(input string tag, input logic [7:0] m, input logic [7:0] d,
                           input logic [7:0] g, input logic c, input int run, input bit poke,
                           output int n_en, output int n_ld, output int n_sd, output int n_busy);
      obs_t o;
      n_en = 0; n_ld = 0; n_sd = 0; n_busy = 0;
      build_trace(m, d, g, c, run);
      @(negedge clk);
      mask = m; dwell = d; gap = g; mode_cont = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // Scramble config inputs: they must be ignored while busy.
      mask = 8'($urandom); dwell = 8'($urandom); gap = 8'($urandom); mode_cont = 1'($urandom);
      for (int i = 0; i < run; i++) begin
         if (i > 0) @(negedge clk);
         start = (poke && i == 3 && exp_q[3].busy) ? 1'b1 : 1'b0;
         o = observe();
         check($sformatf("%s cyc%0d", tag, i), 32'(o), 32'(exp_q[i]));
         n_en   += int'(o.en);
         n_ld   += int'(o.ld);
         n_sd   += int'(o.sd);
         n_busy += int'(o.busy);
      end
      start = 1'b0;
      stop  = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check($sformatf("%s after stop", tag), 32'(observe()),
            32'(obs_t'{sel: exp_q[run-1].sel, en: 1'b0, busy: 1'b0, ld: 1'b0, sd: 1'b0}));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ne, nl, ns, nb;
      logic [7:0] rm, rd, rg;

      tbl[0] = '{8'hFF, 8'd2, 8'd0, 1'b0, 20, 16, 8, 1, 16};
      tbl[1] = '{8'hA4, 8'd1, 8'd3, 1'b0, 12,  3, 3, 1,  9};
      tbl[2] = '{8'h01, 8'd0, 8'd5, 1'b0,  4,  1, 1, 1,  1};
      tbl[3] = '{8'h81, 8'd1, 8'd1, 1'b1,  9,  5, 5, 2,  9};
      tbl[4] = '{8'h18, 8'd3, 8'd2, 1'b0, 12,  6, 2, 1,  8};
      tbl[5] = '{8'h80, 8'd4, 8'd7, 1'b1, 12,  5, 1, 1, 12};
      tbl[6] = '{8'h01, 8'd1, 8'd0, 1'b1,  5,  5, 5, 5,  5};

      #13;
      check("reset outputs", 32'(observe()), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Start with an empty mask, and start together with stop: nothing happens.
      mask = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("mask0 cyc%0d", i), 32'(observe()), 32'd0);
         @(negedge clk);
      end
      mask = 8'hFF; dwell = 8'd2; start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("start+stop cyc%0d", i), 32'(observe()), 32'd0);
         @(negedge clk);
      end

      for (int v = 0; v < 7; v++) begin
         run_case($sformatf("vec%0d", v), tbl[v].mask, tbl[v].dwell, tbl[v].gap,
                  tbl[v].cont, tbl[v].run, 1'b0, ne, nl, ns, nb);
         check($sformatf("vec%0d en count", v), 32'(ne), 32'(tbl[v].n_en));
         check($sformatf("vec%0d line_done count", v), 32'(nl), 32'(tbl[v].n_ld));
         check($sformatf("vec%0d sweep_done count", v), 32'(ns), 32'(tbl[v].n_sd));
         check($sformatf("vec%0d busy count", v), 32'(nb), 32'(tbl[v].n_busy));
      end

      // A second start mid-sweep must leave the sequence untouched.
      run_case("start while busy", 8'hFF, 8'd2, 8'd0, 1'b0, 18, 1'b1, ne, nl, ns, nb);

      for (int r = 0; r < 30; r++) begin
         rm = 8'($urandom_range(1, 255));
         rd = 8'($urandom_range(0, 3));
         rg = 8'($urandom_range(0, 3));
         run_case($sformatf("rand%0d m=%0h d=%0d g=%0d", r, rm, rd, rg), rm, rd, rg,
                  1'($urandom), int'($urandom_range(5, 40)), 1'($urandom), ne, nl, ns, nb);
      end

      // Asynchronous reset between clock edges while a line is on.
      @(negedge clk);
      mask = 8'h30; dwell = 8'd4; gap = 8'd0; mode_cont = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre-reset on line", 32'(observe()),
            32'(obs_t'{sel: 3'd4, en: 1'b1, busy: 1'b1, ld: 1'b0, sd: 1'b0}));
      #2 rst = 1'b1;
      #1 check("async reset clears", 32'(observe()), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_case("after reset", 8'hA4, 8'd1, 8'd3, 1'b0, 12, 1'b0, ne, nl, ns, nb);
      check("after reset busy count", 32'(nb), 32'd9);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
